cp0_regfile: RTL and testbench
==============================

Name: cp0_regfile

Overview:
- Implements the MIPS CP0 register subset: BadVAddr, Count, Compare, Status, Cause and EPC.
- Sits at the memory stage and consumes the exception code that the pipeline hazard/flush logic acts on.
- Provides the EPC value that the flush logic uses as the eret return address.
- Owns the timer interrupt and the exception-entry/eret side effects on Status, Cause, EPC and BadVAddr.

Parameters:
- STATUS_RST, 32'h0040_0000, Status reset value (BEV=1).
- COUNT_DIV, 2, Count increments once every COUNT_DIV clocks (legal values 1 or 2).

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- we_i  in  1  mtc0 write enable (M stage).
- waddr_i  in  5  mtc0 destination register number.
- wdata_i  in  32  mtc0 write data.
- raddr_i  in  5  mfc0 source register number.
- rdata_o  out  32  mfc0 read data; combinational from raddr_i.
- int_i  in  6  external hardware interrupt lines, level-sensitive.
- excepttype_i  in  32  M-stage exception code; 0 means none.
- pc_i  in  32  M-stage instruction address.
- in_delayslot_i  in  1  M-stage instruction is in a branch delay slot.
- bad_addr_i  in  32  faulting address for AdEL/AdES.
- status_o  out  32  current Status.
- cause_o  out  32  current Cause.
- epc_o  out  32  current EPC.
- count_o  out  32  current Count.
- compare_o  out  32  current Compare.
- badvaddr_o  out  32  current BadVAddr.
- timer_int_o  out  1  timer interrupt pending.

Behaviour:
- Register map: 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC. Any other raddr_i reads 0; writes to other addresses are ignored.
- Reset (resetn=0, asynchronous): Status=STATUS_RST; Cause, EPC, Count, Compare, BadVAddr = 0; timer_int_o=0; Count prescaler=0.
- Writable fields via mtc0:
  - Status: IM[15:8], EXL[1], IE[0]. All other bits hold.
  - Cause: IP[9:8] only.
  - EPC, Count, Compare: all 32 bits.
  - BadVAddr: read-only, writes ignored.
- Writes take effect at the next rising edge. Reads return the pre-edge value; there is no internal write-to-read bypass, because E-stage forwarding handles it.
- Cause hardware fields, updated every cycle: IP[15:10] = int_i[5:0], with IP[15] = int_i[5] | timer_int_o.
- Count:
  - Increments by 1 every COUNT_DIV clocks and wraps 32'hFFFF_FFFF -> 0.
  - An mtc0 to Count loads wdata_i and resets the prescaler. The write wins over the increment that cycle.
- Timer:
  - timer_int_o is set at the edge after Count == Compare while Compare != 0.
  - It stays set until an mtc0 to Compare clears it. A Compare write clears it even if the new value equals Count; the compare resumes from the next cycle.
- Exception entry: excepttype_i in {0x1, 0x4, 0x5, 0x8, 0x9, 0xA, 0xC}. On that edge:
  - If Status.EXL==0: EPC = in_delayslot_i ? pc_i-4 : pc_i, and Cause.BD = in_delayslot_i.
  - If Status.EXL==1: EPC and BD are held.
  - Status.EXL = 1.
  - Cause.ExcCode[6:2] = 0x00 (int), 0x04, 0x05, 0x08, 0x09, 0x0A, 0x0C respectively.
  - For 0x4/0x5 only: BadVAddr = bad_addr_i.
- eret (excepttype_i == 0xE): Status.EXL = 0. No other register changes.
- Other nonzero codes are ignored.
- Priority in the same cycle: exception/eret side effects override a simultaneous mtc0 to the same field. The mtc0 is dropped entirely because the instruction is flushed. Count still increments.
- epc_o is a direct register output, so it is valid in the same cycle the eret reaches M.
- Reset mid-operation clears all state immediately, including the prescaler phase and pending timer_int.

Test Plan:
- Reset release, COUNT_DIV=2, run 10 clocks -> count_o=5, status_o=32'h0040_0000, all other outputs 0.
- mtc0 Compare=8, Count=0 -> timer_int_o rises 1 clk after count_o==8 and cause_o[15]=1; mtc0 Compare=100 -> timer_int_o=0 next cycle.
- excepttype_i=0x4, pc_i=0xBFC0_0100, in_delayslot_i=1, bad_addr_i=0x1235 -> epc_o=0xBFC0_00FC, cause_o[31]=1, cause_o[6:2]=4, badvaddr_o=0x1235, status_o[1]=1.
- With EXL=1, excepttype_i=0x8, pc_i=0x100 -> epc_o unchanged, ExcCode=8; then excepttype_i=0xE -> status_o[1]=0.
- Simultaneous mtc0 EPC=0xDEAD_BEEF and excepttype_i=0xC, pc_i=0x200, EXL=0 -> epc_o=0x200, ExcCode=0x0C.
- int_i=6'b000101 -> cause_o[15:10]=6'b000101 next cycle; mtc0 Cause=0x300 -> cause_o[9:8]=2'b11, ExcCode unchanged.

Source files
------------

// File: rtl/cp0_regfile.sv
`default_nettype none
// ============================================================================
// cp0_regfile : MIPS CP0 subset (BadVAddr, Count, Compare, Status, Cause, EPC)
//               with timer interrupt and exception-entry / eret side effects.
// Revision    : 1.0 - initial release
// ============================================================================
module cp0_regfile #(
    parameter logic [31:0] STATUS_RST = 32'h0040_0000,
    parameter int          COUNT_DIV  = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_i,
    output logic [31:0] rdata_o,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] pc_i,
    input  logic        in_delayslot_i,
    input  logic [31:0] bad_addr_i,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] badvaddr_o,
    output logic        timer_int_o
);

    localparam logic [4:0]  c_REG_BADVADDR = 5'd8;
    localparam logic [4:0]  c_REG_COUNT    = 5'd9;
    localparam logic [4:0]  c_REG_COMPARE  = 5'd11;
    localparam logic [4:0]  c_REG_STATUS   = 5'd12;
    localparam logic [4:0]  c_REG_CAUSE    = 5'd13;
    localparam logic [4:0]  c_REG_EPC      = 5'd14;
    localparam logic [31:0] c_STATUS_WMASK = 32'h0000_FF03;
    localparam logic [31:0] c_EXC_ERET     = 32'h0000_000E;

    logic [31:0] status_q, status_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic        timer_q, timer_d;
    logic        presc_q, presc_d;

    logic        count_tick;
    logic        exc_valid;
    logic        exc_bad;
    logic [4:0]  exc_code;
    logic        eret;
    logic        mtc0;

    generate
        if (COUNT_DIV == 1) begin : g_div1
            assign count_tick = 1'b1;
        end else begin : g_div2
            assign count_tick = presc_q;
        end
    endgenerate

    always_comb begin
        exc_valid = 1'b0;
        exc_bad   = 1'b0;
        exc_code  = 5'd0;
        case (excepttype_i)
            32'h1: begin
                exc_valid = 1'b1;
                exc_code  = 5'h00;
            end
            32'h4, 32'h5: begin
                exc_valid = 1'b1;
                exc_bad   = 1'b1;
                exc_code  = excepttype_i[4:0];
            end
            32'h8, 32'h9, 32'hA, 32'hC: begin
                exc_valid = 1'b1;
                exc_code  = excepttype_i[4:0];
            end
            default: ;
        endcase
    end

    assign eret = (excepttype_i == c_EXC_ERET);
    // A flushing instruction's mtc0 never commits.
    assign mtc0 = we_i & ~exc_valid & ~eret;

    always_comb begin
        status_d   = status_q;
        cause_d    = cause_q;
        epc_d      = epc_q;
        compare_d  = compare_q;
        badvaddr_d = badvaddr_q;
        count_d    = count_q + {31'd0, count_tick};
        presc_d    = count_tick ? 1'b0 : ~presc_q;
        timer_d    = timer_q | ((count_q == compare_q) && (compare_q != 32'd0));

        cause_d[15:10] = {int_i[5] | timer_q, int_i[4:0]};

        if (mtc0) begin
            case (waddr_i)
                c_REG_COUNT: begin
                    count_d = wdata_i;
                    presc_d = 1'b0;
                end
                c_REG_COMPARE: begin
                    compare_d = wdata_i;
                    timer_d   = 1'b0;
                end
                c_REG_STATUS: status_d = (status_q & ~c_STATUS_WMASK) | (wdata_i & c_STATUS_WMASK);
                c_REG_CAUSE:  cause_d[9:8] = wdata_i[9:8];
                c_REG_EPC:    epc_d = wdata_i;
                default: ;
            endcase
        end

        if (exc_valid) begin
            // Nested exceptions keep the original return address and BD.
            if (!status_q[1]) begin
                epc_d       = in_delayslot_i ? (pc_i - 32'd4) : pc_i;
                cause_d[31] = in_delayslot_i;
            end
            status_d[1]  = 1'b1;
            cause_d[6:2] = exc_code;
            if (exc_bad) begin
                badvaddr_d = bad_addr_i;
            end
        end else if (eret) begin
            status_d[1] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            status_q   <= STATUS_RST;
            cause_q    <= 32'd0;
            epc_q      <= 32'd0;
            count_q    <= 32'd0;
            compare_q  <= 32'd0;
            badvaddr_q <= 32'd0;
            timer_q    <= 1'b0;
            presc_q    <= 1'b0;
        end else begin
            status_q   <= status_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            badvaddr_q <= badvaddr_d;
            timer_q    <= timer_d;
            presc_q    <= presc_d;
        end
    end

    always_comb begin
        rdata_o = 32'd0;
        case (raddr_i)
            c_REG_BADVADDR: rdata_o = badvaddr_q;
            c_REG_COUNT:    rdata_o = count_q;
            c_REG_COMPARE:  rdata_o = compare_q;
            c_REG_STATUS:   rdata_o = status_q;
            c_REG_CAUSE:    rdata_o = cause_q;
            c_REG_EPC:      rdata_o = epc_q;
            default:        rdata_o = 32'd0;
        endcase
    end

    assign status_o    = status_q;
    assign cause_o     = cause_q;
    assign epc_o       = epc_q;
    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign badvaddr_o  = badvaddr_q;
    assign timer_int_o = timer_q;

endmodule
`default_nettype wire

// File: tb/tb_cp0_regfile.sv
`default_nettype none
// ============================================================================
// tb_cp0_regfile : directed self-checking bench for cp0_regfile.
// Revision       : 1.0 - initial release
// ============================================================================
module tb_cp0_regfile;

    logic        clk;
    logic        resetn;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic [4:0]  raddr_i;
    logic [31:0] rdata_o;
    logic [5:0]  int_i;
    logic [31:0] excepttype_i;
    logic [31:0] pc_i;
    logic        in_delayslot_i;
    logic [31:0] bad_addr_i;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic [31:0] count_o;
    logic [31:0] compare_o;
    logic [31:0] badvaddr_o;
    logic        timer_int_o;

    int total = 0;
    int bad   = 0;

    cp0_regfile #(
        .STATUS_RST (32'h0040_0000),
        .COUNT_DIV  (2)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .we_i           (we_i),
        .waddr_i        (waddr_i),
        .wdata_i        (wdata_i),
        .raddr_i        (raddr_i),
        .rdata_o        (rdata_o),
        .int_i          (int_i),
        .excepttype_i   (excepttype_i),
        .pc_i           (pc_i),
        .in_delayslot_i (in_delayslot_i),
        .bad_addr_i     (bad_addr_i),
        .status_o       (status_o),
        .cause_o        (cause_o),
        .epc_o          (epc_o),
        .count_o        (count_o),
        .compare_o      (compare_o),
        .badvaddr_o     (badvaddr_o),
        .timer_int_o    (timer_int_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we_i = 1'b1; waddr_i = a; wdata_i = d;
        tick();
        we_i = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick(); tick();
        total++; if (status_o !== 32'h0040_0000) begin bad++; $display("FAIL reset_status got=%h exp=%h", status_o, 32'h0040_0000); end
        total++; if ({cause_o, epc_o, count_o, compare_o, badvaddr_o, timer_int_o} !== 161'd0) begin bad++; $display("FAIL reset_zero cause=%h epc=%h count=%h cmp=%h bva=%h tmr=%b exp all 0", cause_o, epc_o, count_o, compare_o, badvaddr_o, timer_int_o); end
        resetn = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        total++; if (count_o !== 32'd5) begin bad++; $display("FAIL count_after_10 got=%0d exp=5", count_o); end
        total++; if (status_o !== 32'h0040_0000) begin bad++; $display("FAIL status_after_10 got=%h exp=00400000", status_o); end
        raddr_i = 5'd12; #1;
        total++; if (rdata_o !== 32'h0040_0000) begin bad++; $display("FAIL read_status got=%h exp=00400000", rdata_o); end
        raddr_i = 5'd7; #1;
        total++; if (rdata_o !== 32'd0) begin bad++; $display("FAIL read_unmapped got=%h exp=0", rdata_o); end
    endtask

    task automatic test_timer();
        bit found;
        mtc0(5'd11, 32'd8);
        mtc0(5'd9, 32'd0);
        total++; if (count_o !== 32'd0) begin bad++; $display("FAIL count_load got=%0d exp=0", count_o); end
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (count_o == 32'd8) begin found = 1'b1; break; end
            total++; if (timer_int_o !== 1'b0) begin bad++; $display("FAIL timer_early cnt=%0d got=%b exp=0", count_o, timer_int_o); end
            tick();
        end
        total++; if (!found) begin bad++; $display("FAIL count_reach8 got=%0d exp=8", count_o); end
        tick();
        total++; if (timer_int_o !== 1'b1) begin bad++; $display("FAIL timer_rise got=%b exp=1", timer_int_o); end
        tick();
        total++; if (cause_o[15] !== 1'b1) begin bad++; $display("FAIL cause_ip7_timer got=%b exp=1", cause_o[15]); end
        mtc0(5'd11, 32'd100);
        total++; if (timer_int_o !== 1'b0 || compare_o !== 32'd100) begin bad++; $display("FAIL timer_clear tmr=%b cmp=%0d exp tmr=0 cmp=100", timer_int_o, compare_o); end
        tick();
        total++; if (cause_o[15] !== 1'b0) begin bad++; $display("FAIL cause_ip7_clear got=%b exp=0", cause_o[15]); end
    endtask

    task automatic test_exception();
        excepttype_i = 32'h4; pc_i = 32'hBFC0_0100; in_delayslot_i = 1'b1; bad_addr_i = 32'h1235;
        tick();
        excepttype_i = 32'h0; in_delayslot_i = 1'b0;
        total++; if (epc_o !== 32'hBFC0_00FC) begin bad++; $display("FAIL exc_epc got=%h exp=bfc000fc", epc_o); end
        total++; if (cause_o[31] !== 1'b1 || cause_o[6:2] !== 5'h04) begin bad++; $display("FAIL exc_cause got=%h exp BD=1 code=04", cause_o); end
        total++; if (badvaddr_o !== 32'h1235) begin bad++; $display("FAIL exc_badvaddr got=%h exp=00001235", badvaddr_o); end
        total++; if (status_o !== 32'h0040_0002) begin bad++; $display("FAIL exc_status got=%h exp=00400002", status_o); end
    endtask

    task automatic test_nested_eret();
        excepttype_i = 32'h8; pc_i = 32'h100; bad_addr_i = 32'h9999;
        tick();
        total++; if (epc_o !== 32'hBFC0_00FC || cause_o[31] !== 1'b1) begin bad++; $display("FAIL nested_hold epc=%h bd=%b exp epc=bfc000fc bd=1", epc_o, cause_o[31]); end
        total++; if (cause_o[6:2] !== 5'h08 || badvaddr_o !== 32'h1235) begin bad++; $display("FAIL nested_code code=%h bva=%h exp code=08 bva=00001235", cause_o[6:2], badvaddr_o); end
        excepttype_i = 32'hE;
        tick();
        excepttype_i = 32'h0;
        total++; if (status_o !== 32'h0040_0000 || epc_o !== 32'hBFC0_00FC || cause_o[6:2] !== 5'h08) begin bad++; $display("FAIL eret st=%h epc=%h code=%h exp st=00400000 epc=bfc000fc code=08", status_o, epc_o, cause_o[6:2]); end
    endtask

    task automatic test_priority();
        we_i = 1'b1; waddr_i = 5'd14; wdata_i = 32'hDEAD_BEEF;
        excepttype_i = 32'hC; pc_i = 32'h200; in_delayslot_i = 1'b0;
        tick();
        we_i = 1'b0; excepttype_i = 32'h0;
        total++; if (epc_o !== 32'h200 || cause_o[6:2] !== 5'h0C || cause_o[31] !== 1'b0) begin bad++; $display("FAIL prio_epc epc=%h code=%h bd=%b exp epc=00000200 code=0c bd=0", epc_o, cause_o[6:2], cause_o[31]); end
        excepttype_i = 32'hE;
        tick();
        excepttype_i = 32'h0;
        mtc0(5'd14, 32'h0000_1234);
        raddr_i = 5'd14; #1;
        total++; if (epc_o !== 32'h1234 || rdata_o !== 32'h1234) begin bad++; $display("FAIL epc_write epc=%h rd=%h exp=00001234", epc_o, rdata_o); end
    endtask

    task automatic test_cause_int();
        int_i = 6'b000101;
        tick();
        total++; if (cause_o[15:10] !== 6'b000101) begin bad++; $display("FAIL cause_ip got=%b exp=000101", cause_o[15:10]); end
        mtc0(5'd13, 32'h0000_0300);
        total++; if (cause_o !== 32'h0000_1730) begin bad++; $display("FAIL cause_write got=%h exp=00001730", cause_o); end
        int_i = 6'd0;
    endtask

    task automatic test_status_count();
        mtc0(5'd12, 32'hFFFF_FFFF);
        total++; if (status_o !== 32'h0040_FF03) begin bad++; $display("FAIL status_mask got=%h exp=0040ff03", status_o); end
        mtc0(5'd8, 32'h5);
        mtc0(5'd3, 32'h77);
        raddr_i = 5'd3; #1;
        total++; if (badvaddr_o !== 32'h1235 || rdata_o !== 32'd0) begin bad++; $display("FAIL ro_ignore bva=%h rd3=%h exp bva=00001235 rd3=0", badvaddr_o, rdata_o); end
        mtc0(5'd9, 32'hFFFF_FFFF);
        total++; if (count_o !== 32'hFFFF_FFFF) begin bad++; $display("FAIL count_max got=%h exp=ffffffff", count_o); end
        tick();
        total++; if (count_o !== 32'hFFFF_FFFF) begin bad++; $display("FAIL count_presc got=%h exp=ffffffff", count_o); end
        tick();
        total++; if (count_o !== 32'd0) begin bad++; $display("FAIL count_wrap got=%h exp=0", count_o); end
    endtask

    task automatic test_reset_mid();
        mtc0(5'd11, 32'd3);
        for (int i = 0; i < 10; i++) tick();
        total++; if (timer_int_o !== 1'b1) begin bad++; $display("FAIL timer_pre_reset got=%b exp=1", timer_int_o); end
        #2 resetn = 1'b0;
        #1;
        total++; if (status_o !== 32'h0040_0000 || count_o !== 32'd0 || epc_o !== 32'd0 || timer_int_o !== 1'b0 || compare_o !== 32'd0) begin bad++; $display("FAIL async_reset st=%h cnt=%h epc=%h tmr=%b cmp=%h", status_o, count_o, epc_o, timer_int_o, compare_o); end
        tick();
        resetn = 1'b1;
        tick();
        total++; if (count_o !== 32'd0) begin bad++; $display("FAIL presc_reset got=%0d exp=0", count_o); end
        tick();
        total++; if (count_o !== 32'd1) begin bad++; $display("FAIL presc_reset2 got=%0d exp=1", count_o); end
    endtask

    initial begin
        resetn = 1'b0; we_i = 1'b0; waddr_i = 5'd0; wdata_i = 32'd0; raddr_i = 5'd0;
        int_i = 6'd0; excepttype_i = 32'd0; pc_i = 32'd0; in_delayslot_i = 1'b0; bad_addr_i = 32'd0;
        test_reset();
        test_timer();
        test_exception();
        test_nested_eret();
        test_priority();
        test_cause_int();
        test_status_count();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
